// File: rtl/aes128_iter_engine.sv
// aes128_iter_engine: iterative AES-128 encryptor evaluating UNROLL rounds per clock with valid/ready handshakes
module aes128_iter_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t fsm_q, fsm_d;
  logic [127:0] state_q, state_d, rkey_q, rkey_d, ct_q, ct_d, s, rk;
  logic [3:0] rnd_q, rnd_d, r;
  logic last;
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("UNROLL must be 1, 2, 5 or 10");
  end
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, v;
    p = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        o[127-8*(4*c+j) -: 8] = sbox(a[127-8*(4*((c+j)%4)+j) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] a);
    logic [127:0] o;
    logic [7:0] x0, x1, x2, x3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {x0, x1, x2, x3} = a[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3,
                           x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3,
                           x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3,
                           xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3)};
    end
    return o;
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 2; i <= 10; i++)
      c = (4'(i) <= n) ? xt(c) : c;
    return c;
  endfunction
  function automatic logic [127:0] keygen(input logic [127:0] a, input logic [3:0] n);
    logic [31:0] t, w0, w1, w2, w3;
    t = a[31:0];
    t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon(n), 24'h0};
    w0 = a[127:96] ^ t;
    w1 = a[95:64] ^ w0;
    w2 = a[63:32] ^ w1;
    w3 = a[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  always_comb begin
    s = state_q;
    rk = rkey_q;
    r = rnd_q;
    for (int k = 0; k < UNROLL; k++) begin
      r = rnd_q + 4'(k);
      rk = keygen(rk, r);
      s = sub_shift(s);
      s = (r < 4'd10 ? mix(s) : s) ^ rk;
    end
  end
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    rkey_d = rkey_q;
    rnd_d = rnd_q;
    ct_d = ct_q;
    last = rnd_q == 4'(11 - UNROLL);
    if (fsm_q == IDLE && in_valid) begin
      fsm_d = RUN;
      state_d = plaintext ^ key;
      rkey_d = key;
      rnd_d = 4'd1;
    end else if (fsm_q == RUN) begin
      fsm_d = last ? DONE : RUN;
      state_d = s;
      rkey_d = rk;
      rnd_d = last ? 4'd0 : rnd_q + 4'(UNROLL);
      ct_d = last ? s : ct_q;
    end else if (fsm_q == DONE && out_ready) begin
      fsm_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      fsm_q <= IDLE;
      state_q <= '0;
      rkey_q <= '0;
      ct_q <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      rkey_q <= rkey_d;
      ct_q <= ct_d;
      rnd_q <= rnd_d;
    end
  end
  assign in_ready = fsm_q == IDLE;
  assign out_valid = fsm_q == DONE;
  assign busy = fsm_q != IDLE;
  assign ciphertext = ct_q;
endmodule

// File: tb/tb_aes128_iter_engine.sv
// tb_aes128_iter_engine: directed FIPS-197 vector bench across all legal unroll factors
module tb_aes128_iter_engine;
  localparam int UN [4] = '{1, 2, 5, 10};
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] in_valid = '0;
  logic [3:0] out_ready = '0;
  logic [3:0] in_ready, out_valid, busy;
  logic [127:0] pt = '0;
  logic [127:0] key = '0;
  logic [127:0] ct [4];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_iter_engine #(.UNROLL(UN[g])) u_dut (
      .clock(clock),
      .resetn(resetn),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .plaintext(pt),
      .key(key),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .ciphertext(ct[g]),
      .busy(busy[g])
    );
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic wait_out(input int i, output int lat);
    lat = 0;
    while (!out_valid[i] && lat < 40) begin
      tick;
      lat++;
    end
  endtask
  task automatic run_blk(input int i, input logic [127:0] p, input logic [127:0] k,
                         input logic [127:0] c, input bit scribble);
    int lat;
    pt = p;
    key = k;
    in_valid[i] = 1'b1;
    tick;
    in_valid[i] = 1'b0;
    chk($sformatf("busy_after_accept_u%0d", UN[i]), 128'(busy[i]), 128'(1));
    lat = 0;
    while (!out_valid[i] && lat < 40) begin
      if (scribble) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        in_valid[i] = ~in_valid[i];
      end
      tick;
      lat++;
    end
    in_valid[i] = 1'b0;
    chk($sformatf("latency_u%0d", UN[i]), 128'(lat), 128'(10 / UN[i]));
    chk($sformatf("ciphertext_u%0d", UN[i]), ct[i], c);
  endtask
  initial begin
    int lat;
    bit seen;
    tick;
    tick;
    chk("rst_in_ready", 128'(in_ready), 128'hf);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_ct", ct[0], 128'h0);
    resetn = 1'b1;
    tick;
    out_ready[0] = 1'b1;
    run_blk(0, P1, K1, C1, 1'b0);
    tick;
    chk("c1_valid_one_cycle", 128'(out_valid[0]), 128'h0);
    chk("c1_back_idle", 128'(in_ready[0]), 128'h1);
    pt = P2;
    key = K2;
    in_valid[0] = 1'b1;
    tick;
    in_valid[0] = 1'b0;
    tick;
    chk("b_round1_state", g_dut[0].u_dut.state_q, R1);
    wait_out(0, lat);
    chk("b_latency", 128'(lat + 1), 128'(10));
    chk("b_ciphertext", ct[0], C2);
    tick;
    out_ready[0] = 1'b0;
    run_blk(0, P1, K1, C1, 1'b0);
    pt = P2;
    key = K2;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick;
      chk("bp_out_valid", 128'(out_valid[0]), 128'h1);
      chk("bp_ct_stable", ct[0], C1);
      chk("bp_in_ready", 128'(in_ready[0]), 128'h0);
    end
    out_ready[0] = 1'b1;
    tick;
    chk("bp_release_idle", 128'(in_ready[0]), 128'h1);
    chk("bp_release_valid", 128'(out_valid[0]), 128'h0);
    run_blk(0, P2, K2, C2, 1'b0);
    tick;
    pt = P1;
    key = K1;
    in_valid[0] = 1'b1;
    tick;
    in_valid[0] = 1'b0;
    tick;
    tick;
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'h0);
    chk("mid_rst_busy", 128'(busy[0]), 128'h0);
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'h1);
    chk("mid_rst_ct", ct[0], 128'h0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      seen |= out_valid[0];
    end
    chk("mid_rst_no_emit", 128'(seen), 128'h0);
    run_blk(0, P1, K1, C1, 1'b0);
    tick;
    for (int i = 1; i < 4; i++) begin
      out_ready[i] = 1'b1;
      pt = P1;
      key = K1;
      in_valid[i] = 1'b1;
      tick;
      pt = P2;
      key = K2;
      wait_out(i, lat);
      chk($sformatf("b2b_lat1_u%0d", UN[i]), 128'(lat), 128'(10 / UN[i]));
      chk($sformatf("b2b_ct1_u%0d", UN[i]), ct[i], C1);
      tick;
      chk($sformatf("b2b_idle_u%0d", UN[i]), 128'(in_ready[i]), 128'h1);
      tick;
      in_valid[i] = 1'b0;
      chk($sformatf("b2b_period_u%0d", UN[i]), 128'(busy[i]), 128'h1);
      wait_out(i, lat);
      chk($sformatf("b2b_lat2_u%0d", UN[i]), 128'(lat), 128'(10 / UN[i]));
      chk($sformatf("b2b_ct2_u%0d", UN[i]), ct[i], C2);
      tick;
      chk($sformatf("b2b_drop_u%0d", UN[i]), 128'(out_valid[i]), 128'h0);
    end
    run_blk(0, P2, K2, C2, 1'b1);
    tick;
    chk("scribble_drop", 128'(out_valid[0]), 128'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
